// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - decoded ID-stage fields presented to the ID/EX operand stage
interface alu_operand_stage_if #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
);
  logic              ID_Valid;
  logic [WIDTH-1:0]  ID_RsData;
  logic [WIDTH-1:0]  ID_RtData;
  logic [WIDTH-1:0]  ID_Imm;
  logic [REG_AW-1:0] ID_Rs;
  logic [REG_AW-1:0] ID_Rt;
  logic [REG_AW-1:0] ID_Rd;
  logic [1:0]        ID_ALUOp;
  logic [2:0]        ID_Funct;
  logic              ID_ALUSrc;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              ID_MemWrite;

  modport master (
    output ID_Valid, ID_RsData, ID_RtData, ID_Imm, ID_Rs, ID_Rt, ID_Rd,
           ID_ALUOp, ID_Funct, ID_ALUSrc, ID_RegWrite, ID_MemRead, ID_MemWrite
  );

  modport slave (
    input ID_Valid, ID_RsData, ID_RtData, ID_Imm, ID_Rs, ID_Rt, ID_Rd,
          ID_ALUOp, ID_Funct, ID_ALUSrc, ID_RegWrite, ID_MemRead, ID_MemWrite
  );
endinterface

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX register with ALU control decode, operand forwarding and load-use detect
module alu_operand_stage #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  alu_operand_stage_if.slave id,
  input  logic              MEM_RegWrite,
  input  logic [REG_AW-1:0] MEM_Rd,
  input  logic [WIDTH-1:0]  MEM_Result,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_Rd,
  input  logic [WIDTH-1:0]  WB_Data,
  output logic [WIDTH-1:0]  Source1,
  output logic [WIDTH-1:0]  Source2,
  output logic [3:0]        ALU_Ctrl,
  output logic [WIDTH-1:0]  EX_StoreData,
  output logic              EX_Valid,
  output logic [REG_AW-1:0] EX_Rd,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              Hazard_LoadUse
);

  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_PASS = 4'b0000;

  logic              valid_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic              reg_write_q, mem_read_q, mem_write_q, alu_src_q;
  logic [3:0]        ctrl_q;
  logic [WIDTH-1:0]  rs_data_q, rt_data_q, imm_q;

  logic [3:0]        ctrl_dec;
  logic [WIDTH-1:0]  fwd_a, fwd_b;

  function automatic logic [WIDTH-1:0] forward(
    input logic              valid,
    input logic [REG_AW-1:0] idx,
    input logic [WIDTH-1:0]  reg_data,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic [WIDTH-1:0]  mem_val,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [WIDTH-1:0]  wb_val
  );
    logic [WIDTH-1:0] r;
    r = reg_data;
    if (!valid || idx == '0) r = '0;
    else if (mem_we && mem_rd == idx) r = mem_val;
    else if (wb_we && wb_rd == idx) r = wb_val;
    return r;
  endfunction

  always_comb begin
    ctrl_dec = CTRL_PASS;
    unique case (id.ID_ALUOp)
      2'b00: ctrl_dec = CTRL_ADD;
      2'b01: ctrl_dec = CTRL_SUB;
      2'b11: ctrl_dec = CTRL_PASS;
      default: begin
        unique case (id.ID_Funct)
          3'b000:  ctrl_dec = CTRL_ADD;
          3'b001:  ctrl_dec = CTRL_SUB;
          3'b010:  ctrl_dec = CTRL_SLT;
          default: ctrl_dec = CTRL_PASS;
        endcase
      end
    endcase
  end

  always_comb begin
    fwd_a = forward(valid_q, rs_q, rs_data_q, MEM_RegWrite, MEM_Rd, MEM_Result,
                    WB_RegWrite, WB_Rd, WB_Data);
    fwd_b = forward(valid_q, rt_q, rt_data_q, MEM_RegWrite, MEM_Rd, MEM_Result,
                    WB_RegWrite, WB_Rd, WB_Data);
  end

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      ctrl_q      <= CTRL_ADD;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
    end else if (Stall) begin
      // Re-capture forwarded operands so they survive their producer retiring mid-stall.
      rs_data_q <= fwd_a;
      rt_data_q <= fwd_b;
    end else begin
      valid_q     <= id.ID_Valid;
      rs_q        <= id.ID_Rs;
      rt_q        <= id.ID_Rt;
      rd_q        <= id.ID_Rd;
      reg_write_q <= id.ID_RegWrite & id.ID_Valid;
      mem_read_q  <= id.ID_MemRead & id.ID_Valid;
      mem_write_q <= id.ID_MemWrite & id.ID_Valid;
      alu_src_q   <= id.ID_ALUSrc;
      ctrl_q      <= ctrl_dec;
      rs_data_q   <= id.ID_RsData;
      rt_data_q   <= id.ID_RtData;
      imm_q       <= id.ID_Imm;
    end
  end

  assign Source1      = fwd_a;
  assign Source2      = !valid_q ? '0 : (alu_src_q ? imm_q : fwd_b);
  assign EX_StoreData = fwd_b;
  assign ALU_Ctrl     = ctrl_q;
  assign EX_Valid     = valid_q;
  assign EX_Rd        = rd_q;
  assign EX_RegWrite  = reg_write_q;
  assign EX_MemRead   = mem_read_q;
  assign EX_MemWrite  = mem_write_q;

  assign Hazard_LoadUse = valid_q & mem_read_q & (rd_q != '0) &
                          ((rd_q == id.ID_Rs) | ((rd_q == id.ID_Rt) & ~id.ID_ALUSrc));

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - self-checking bench for alu_operand_stage
module tb_alu_operand_stage;
  localparam int W  = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst, Stall, Flush;
  logic MEM_RegWrite, WB_RegWrite;
  logic [AW-1:0] MEM_Rd, WB_Rd;
  logic [W-1:0] MEM_Result, WB_Data;
  logic [W-1:0] Source1, Source2, EX_StoreData;
  logic [3:0] ALU_Ctrl;
  logic EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, Hazard_LoadUse;
  logic [AW-1:0] EX_Rd;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.WIDTH(W), .REG_AW(AW)) id ();

  alu_operand_stage #(.WIDTH(W), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .id(id),
    .MEM_RegWrite(MEM_RegWrite), .MEM_Rd(MEM_Rd), .MEM_Result(MEM_Result),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
    .Source1(Source1), .Source2(Source2), .ALU_Ctrl(ALU_Ctrl),
    .EX_StoreData(EX_StoreData), .EX_Valid(EX_Valid), .EX_Rd(EX_Rd),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .Hazard_LoadUse(Hazard_LoadUse)
  );

  // Reference: the instruction currently held, as the ISA-level record it represents.
  typedef struct packed {
    logic          v;
    logic [AW-1:0] rs, rt, rd;
    logic          rw, mr, mw, src;
    logic [3:0]    ctrl;
    logic [W-1:0]  a, b, imm;
  } op_t;

  op_t m;

  function automatic op_t bubble();
    op_t x;
    x = '0;
    x.ctrl = 4'b0010;
    return x;
  endfunction

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0000;
    if (f == 3'd0) return 4'b0010;
    if (f == 3'd1) return 4'b0110;
    if (f == 3'd2) return 4'b0111;
    return 4'b0000;
  endfunction

  function automatic logic [W-1:0] ref_fwd(input logic [AW-1:0] idx, input logic [W-1:0] held);
    if (!m.v || idx == 0) return '0;
    if (MEM_RegWrite && MEM_Rd == idx) return MEM_Result;
    if (WB_RegWrite && WB_Rd == idx) return WB_Data;
    return held;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] ea, eb, es2;
    logic ehaz;
    ea   = ref_fwd(m.rs, m.a);
    eb   = ref_fwd(m.rt, m.b);
    es2  = !m.v ? '0 : (m.src ? m.imm : eb);
    ehaz = m.v && m.mr && m.rd != 0 &&
           (m.rd == id.ID_Rs || (m.rd == id.ID_Rt && !id.ID_ALUSrc));
    chk({tag, "_src1"},  Source1, ea);
    chk({tag, "_src2"},  Source2, es2);
    chk({tag, "_store"}, EX_StoreData, eb);
    chk({tag, "_ctrl"},  {12'd0, ALU_Ctrl}, {12'd0, m.ctrl});
    chk({tag, "_valid"}, {15'd0, EX_Valid}, {15'd0, m.v});
    chk({tag, "_rd"},    {13'd0, EX_Rd}, {13'd0, m.rd});
    chk({tag, "_ctl3"},  {13'd0, EX_RegWrite, EX_MemRead, EX_MemWrite}, {13'd0, m.rw, m.mr, m.mw});
    chk({tag, "_haz"},   {15'd0, Hazard_LoadUse}, {15'd0, ehaz});
  endtask

  task automatic tick();
    op_t n;
    if (rst || Flush) m = bubble();
    else if (Stall) begin
      n = m;
      n.a = ref_fwd(m.rs, m.a);
      n.b = ref_fwd(m.rt, m.b);
      m = n;
    end else begin
      n.v = id.ID_Valid;   n.rs = id.ID_Rs;   n.rt = id.ID_Rt;   n.rd = id.ID_Rd;
      n.rw = id.ID_RegWrite & id.ID_Valid;
      n.mr = id.ID_MemRead & id.ID_Valid;
      n.mw = id.ID_MemWrite & id.ID_Valid;
      n.src = id.ID_ALUSrc;
      n.ctrl = ref_ctrl(id.ID_ALUOp, id.ID_Funct);
      n.a = id.ID_RsData;  n.b = id.ID_RtData;  n.imm = id.ID_Imm;
      m = n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [W-1:0] rsd,
                        input logic [AW-1:0] rt, input logic [W-1:0] rtd, input logic [AW-1:0] rd,
                        input logic [1:0] op, input logic [2:0] f, input logic src,
                        input logic [W-1:0] imm, input logic rw, input logic mr, input logic mw);
    id.ID_Valid = v;  id.ID_Rs = rs;  id.ID_RsData = rsd;  id.ID_Rt = rt;  id.ID_RtData = rtd;
    id.ID_Rd = rd;  id.ID_ALUOp = op;  id.ID_Funct = f;  id.ID_ALUSrc = src;  id.ID_Imm = imm;
    id.ID_RegWrite = rw;  id.ID_MemRead = mr;  id.ID_MemWrite = mw;
  endtask

  initial begin
    m = bubble();
    rst = 1'b1;  Stall = 1'b0;  Flush = 1'b0;
    MEM_RegWrite = 0; MEM_Rd = 0; MEM_Result = 0;
    WB_RegWrite = 0;  WB_Rd = 0;  WB_Data = 0;
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", {15'd0, EX_Valid}, 16'd0);
    chk("rst_ctrl",  {12'd0, ALU_Ctrl}, 16'h0002);
    chk("rst_src1",  Source1, 16'd0);
    chk("rst_src2",  Source2, 16'd0);
    chk("rst_store", EX_StoreData, 16'd0);
    chk("rst_ctl3",  {13'd0, EX_RegWrite, EX_MemRead, EX_MemWrite}, 16'd0);
    chk("rst_rd",    {13'd0, EX_Rd}, 16'd0);
    chk("rst_haz",   {15'd0, Hazard_LoadUse}, 16'd0);

    set_id(1, 3'd1, 16'd5, 3'd2, 16'd9, 3'd3, 2'b10, 3'b010, 0, 16'h00FF, 1, 0, 0);
    tick();
    chk("slt_src1",  Source1, 16'd5);
    chk("slt_src2",  Source2, 16'd9);
    chk("slt_ctrl",  {12'd0, ALU_Ctrl}, 16'h0007);
    chk("slt_valid", {15'd0, EX_Valid}, 16'd1);
    check_all("slt");

    set_id(1, 3'd3, 16'h0011, 3'd2, 16'd0, 3'd5, 2'b00, 0, 0, 0, 1, 0, 0);
    tick();
    MEM_RegWrite = 1; MEM_Rd = 3; MEM_Result = 16'h00AA;
    WB_RegWrite = 1;  WB_Rd = 3;  WB_Data = 16'h00BB;
    #1;
    chk("fwd_mem", Source1, 16'h00AA);
    MEM_RegWrite = 0;
    #1;
    chk("fwd_wb", Source1, 16'h00BB);
    set_id(1, 3'd0, 16'h0077, 3'd2, 16'd0, 3'd5, 2'b00, 0, 0, 0, 1, 0, 0);
    WB_Rd = 0;
    tick();
    chk("fwd_r0", Source1, 16'd0);
    check_all("fwd");
    WB_RegWrite = 0;

    set_id(1, 3'd1, 16'h0001, 3'd5, 16'h0000, 3'd6, 2'b01, 0, 0, 0, 1, 0, 0);
    tick();
    WB_RegWrite = 1; WB_Rd = 5; WB_Data = 16'h1234;
    Stall = 1;
    set_id(1, 3'd2, 16'hDEAD, 3'd7, 16'hBEEF, 3'd1, 2'b11, 0, 1, 16'h5555, 0, 1, 1);
    #1;
    chk("stall0_src2", Source2, 16'h1234);
    for (int i = 1; i <= 3; i++) begin
      tick();
      WB_RegWrite = 0;
      #1;
      chk("stall_src2", Source2, 16'h1234);
      chk("stall_ctrl", {12'd0, ALU_Ctrl}, 16'h0006);
      chk("stall_rd",   {13'd0, EX_Rd}, 16'd6);
      check_all("stall");
    end

    Stall = 1; Flush = 1;
    set_id(1, 3'd1, 16'h0003, 3'd2, 16'h0004, 3'd3, 2'b00, 0, 0, 0, 1, 0, 0);
    tick();
    chk("flush_valid", {15'd0, EX_Valid}, 16'd0);
    chk("flush_rw",    {15'd0, EX_RegWrite}, 16'd0);
    chk("flush_ctrl",  {12'd0, ALU_Ctrl}, 16'h0002);
    Stall = 0; Flush = 0;

    set_id(1, 3'd1, 16'd0, 3'd2, 16'd0, 3'd4, 2'b00, 0, 1, 16'h0010, 1, 1, 0);
    tick();
    id.ID_Rs = 4; id.ID_Rt = 2; id.ID_ALUSrc = 0;
    #1;
    chk("haz_rs", {15'd0, Hazard_LoadUse}, 16'd1);
    id.ID_Rs = 1; id.ID_Rt = 4; id.ID_ALUSrc = 1;
    #1;
    chk("haz_rt_imm", {15'd0, Hazard_LoadUse}, 16'd0);
    set_id(1, 3'd1, 16'd0, 3'd2, 16'd0, 3'd0, 2'b00, 0, 1, 16'h0010, 1, 1, 0);
    tick();
    id.ID_Rs = 0; id.ID_Rt = 0; id.ID_ALUSrc = 0;
    #1;
    chk("haz_rd0", {15'd0, Hazard_LoadUse}, 16'd0);
    check_all("haz");

    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      Stall = ($urandom_range(0, 3) == 0);
      set_id($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), W'($urandom),
             AW'($urandom_range(0, 7)), W'($urandom), AW'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      MEM_RegWrite = 1'($urandom_range(0, 1)); MEM_Rd = AW'($urandom_range(0, 7));
      MEM_Result = W'($urandom);
      WB_RegWrite = 1'($urandom_range(0, 1));  WB_Rd = AW'($urandom_range(0, 7));
      WB_Data = W'($urandom);
      #1;
      check_all("rnd");
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
